muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences RV32M multiply/divide ops for the Execute stage. Holds E via a stall request while
//  an iterative shift-add multiplier / restoring divider runs, then presents the result on one
//  DONE cycle. Sits beside the E-stage ALU. Hazard unit ORs stall_o into its F/D/E stall logic.
//  Writeback muxes result_o over ALUResultE when done_o=1.
// PARAMETERS
//  XLEN    32   operand/result width; only 32 is supported
//  CNT_W   5    iteration counter width; iterations = 2**CNT_W = XLEN
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  start_i      in   1     M-ext op valid in E; held high by pipeline while stalled
//  op_i         in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  SrcAE_i      in   32    rs1 operand (forwarded)
//  SrcBE_i      in   32    rs2 operand (forwarded)
//  flush_i      in   1     E-stage flush (taken branch/jump); aborts op
//  stall_o      out  1     hold F/D/E this cycle
//  done_o       out  1     result_o valid; single-cycle pulse
//  result_o     out  32    selected result word
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, stall_o=0, done_o=0, result_o=0, all operand/acc regs=0.
//  FSM: IDLE -> MUL | DIV | DONE. MUL/DIV -> DONE after iteration 31. DONE -> IDLE always.
//  IDLE: start_i=1 and flush_i=0 -> accept. stall_o asserted combinationally that same cycle.
//   Latch |A|, |B| (signed ops only), result sign, op.
//   Sign rules: MULH both signed. MULHSU A signed only. DIV/REM signed. Unsigned ops use raw values.
//  MUL: 32 cycles, one shift-add per cycle into 64-bit acc. Counter increments 0..31.
//   Final: negate 64-bit acc if sign. MUL -> low 32 bits; MULH/MULHSU/MULHU -> high 32 bits.
//  DIV: 32 restoring-division steps, 1 quotient bit per cycle.
//   Quotient is negated if signs differ. Remainder takes the sign of the dividend.
//  Div by zero (SrcBE_i=0): IDLE -> DONE directly. Q=0xFFFFFFFF, R=SrcAE_i.
//  Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): IDLE -> DONE directly.
//   Q=0x80000000, R=0.
//  Latency (accept at cycle 0): iterative -> done_o at cycle 33, stall_o high cycles 0..32.
//   Special cases -> done_o at cycle 1, stall_o high cycle 0 only.
//  DONE: stall_o=0, done_o=1, result_o valid. Instruction advances this cycle.
//   start_i is ignored in DONE, so the held op never re-triggers.
//  result_o holds its last value outside DONE. Consumers qualify with done_o.
//  flush_i=1 in any state: next state IDLE, counter=0, no done_o. stall_o drops the same cycle.
//  flush_i=1 together with start_i in IDLE: flush wins, no accept.
//  Operand changes while busy are ignored; latched copies are used.
//  rst mid-operation: back to reset values on the next edge; partial result discarded.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL* ops use one combinational 33x33 signed multiply.
//   Path is IDLE -> DONE, latency 1, stall_o high cycle 0 only. DIV path unchanged.
//  Undefined: iterative 32-cycle multiply as above. No multiplier is inferred.
// TESTING
//  MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; done_o at cycle 33 (cycle 1 with FAST_MUL_EN).
//   stall_o high 33 cycles (1 with FAST_MUL_EN).
//  MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2; REM same -> 0xFFFFFFFE.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//   All four: done_o at cycle 1.
//  DIVU started, flush_i pulsed at cycle 10 -> stall_o=0 at cycle 10, state IDLE at 11.
//   done_o never asserted; a new op accepted at cycle 11 completes correctly.
//  rst asserted at cycle 20 of MUL -> all outputs 0 at cycle 21.
//   start_i held high through DONE -> exactly one done_o pulse per accepted op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the Execute stage: shift-add multiplier and restoring divider.
// Optional MULDIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle 33x33 signed multiply.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] SrcAE_i,
    input  logic [XLEN-1:0] SrcBE_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    // Handshake: an op is accepted in IDLE when start_i=1 and flush_i=0; stall_o stays high until
    // the result cycle, where done_o pulses once with result_o valid and stall_o low.
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   result_q;
    logic [1:0]        op_q;
    logic              neg_q;
    logic              stall, done;

    logic            a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, neg_in;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    assign a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign a_neg    = a_signed & SrcAE_i[XLEN-1];
    assign b_neg    = b_signed & SrcBE_i[XLEN-1];
    assign a_abs    = a_neg ? -SrcAE_i : SrcAE_i;
    assign b_abs    = b_neg ? -SrcBE_i : SrcBE_i;
    assign is_div   = op_i[2];
    // Remainder follows the dividend's sign; quotient and products follow the sign product.
    assign neg_in   = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = (SrcBE_i == '0);
    assign div_ovf  = ((op_i == 3'd4) || (op_i == 3'd6)) &&
                      (SrcAE_i == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE_i == '1);
    assign special_res = div_zero ? (op_i[1] ? SrcAE_i : '1)
                                  : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration step of each engine, computed from the current accumulator.
    logic [XLEN:0]     mul_add, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_nxt, mul_prod, div_nxt;
    logic [XLEN-1:0]   mul_res, q_fin, r_fin, div_res;

    assign mul_add   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_nxt   = {mul_add, acc_q[XLEN-1:1]};
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_nxt   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign mul_prod = neg_q ? -mul_nxt : mul_nxt;
    assign mul_res  = (op_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    assign q_fin    = neg_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
    assign r_fin    = neg_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
    assign div_res  = op_q[1] ? r_fin : q_fin;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;
    assign fast_prod = $signed({a_signed & SrcAE_i[XLEN-1], SrcAE_i}) *
                       $signed({b_signed & SrcBE_i[XLEN-1], SrcBE_i});
    assign fast_res  = (op_i[1:0] == 2'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    stall = 1'b1;
                    if (is_div) state_d = (div_zero || div_ovf) ? DONE : DIV;
`ifdef MULDIV_FAST_MUL_EN
                    else        state_d = DONE;
`else
                    else        state_d = MUL;
`endif
                end
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (&cnt_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            stall   = 1'b0;
            done    = 1'b0;
        end
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (state_d != IDLE) begin
                        op_q  <= op_i[1:0];
                        neg_q <= neg_in;
                        if (is_div) begin
                            acc_q   <= {{XLEN{1'b0}}, a_abs};
                            mcand_q <= b_abs;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, b_abs};
                            mcand_q <= a_abs;
                        end
                        if (state_d == DONE) begin
`ifdef MULDIV_FAST_MUL_EN
                            result_q <= is_div ? special_res : fast_res;
`else
                            result_q <= special_res;
`endif
                        end
                    end
                end
                MUL: begin
                    acc_q <= mul_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (state_d == DONE) result_q <= mul_res;
                end
                DIV: begin
                    acc_q <= div_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (state_d == DONE) result_q <= div_res;
                end
                default: cnt_q <= '0;
            endcase
            if (flush_i) cnt_q <= '0;
        end
    end

    assign stall_o  = stall;
    assign done_o   = done;
    assign result_o = result_q;

endmodule
